// File: rtl/bin_to_bcd_digits_if.sv
// Request/result bundle between the application datapath (master) and the
// binary-to-BCD converter (slave).
interface bin_to_bcd_digits_if #(
  parameter int W = 27
);
  logic         in_valid;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic [31:0]  bcd;
  logic [7:0]   an_on;
  logic         overflow;

  modport master (
    output in_valid, value,
    input  busy, done, bcd, an_on, overflow
  );

  modport slave (
    input  in_valid, value,
    output busy, done, bcd, an_on, overflow
  );
endinterface

// File: rtl/bin_to_bcd_digits.sv
// Sequential double-dabble converter, one iteration per clock, feeding eight
// packed BCD digits and a leading-zero blanking mask to the display driver.
module bin_to_bcd_digits #(
  parameter int W        = 27,
  parameter bit BLANK_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  bin_to_bcd_digits_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  localparam logic [W-1:0] MAX_VAL  = W'(99_999_999);
  localparam logic [4:0]   CNT_LAST = 5'(W - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_shift;
  logic [31:0]  r_scratch;
  logic [4:0]   r_cnt;
  logic         r_ovf_pend;
  logic [31:0]  r_bcd;
  logic [7:0]   r_an_on;
  logic         r_overflow;
  logic         r_done;

  logic [31:0]  w_adj;
  logic [31:0]  w_scratch_nxt;
  logic [W-1:0] w_shift_nxt;
  logic [7:0]   w_mask;
  logic         w_zero;
  logic         w_last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        w_last = (r_cnt == CNT_LAST);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Add-3 on every nibble >= 5, then shift {scratch, shift_reg} left by one.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < 8; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
    {w_scratch_nxt, w_shift_nxt} = {w_adj[30:0], r_shift, 1'b0};
  end

  // Digit i is blanked only when it and every more significant digit are zero;
  // the units digit always stays lit.
  always_comb begin
    w_mask = 8'h00;
    w_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      w_zero    = w_zero & (w_scratch_nxt[4*i +: 4] == 4'd0);
      w_mask[i] = w_zero;
    end
    if (!BLANK_EN || r_ovf_pend) w_mask = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_an_on    <= BLANK_EN ? 8'hFE : 8'h00;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.in_valid) begin
          r_shift    <= bus.value;
          r_scratch  <= '0;
          r_cnt      <= '0;
          r_ovf_pend <= (bus.value > MAX_VAL);
        end
      end else begin
        r_shift   <= w_shift_nxt;
        r_scratch <= w_scratch_nxt;
        r_cnt     <= r_cnt + 5'd1;
        if (w_last) begin
          r_bcd      <= r_ovf_pend ? 32'hFFFF_FFFF : w_scratch_nxt;
          r_overflow <= r_ovf_pend;
          r_an_on    <= w_mask;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = (r_state == S_SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.an_on    = r_an_on;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed bench for bin_to_bcd_digits: one blanking instance and one
// non-blanking instance share the same stimulus.
module tb_bin_to_bcd_digits;

  localparam int W = 27;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  bin_to_bcd_digits_if #(.W(W)) u_if ();
  bin_to_bcd_digits_if #(.W(W)) u_if_nb ();

  assign u_if_nb.in_valid = u_if.in_valid;
  assign u_if_nb.value    = u_if.value;

  bin_to_bcd_digits #(.W(W), .BLANK_EN(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  bin_to_bcd_digits #(.W(W), .BLANK_EN(1'b0)) u_dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a request for one cycle; returns #1 after the accepting edge.
  task automatic accept(input logic [W-1:0] val);
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.value    = val;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
  endtask

  // Count edges until done is seen (#1 after the edge); also counts busy samples.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 32'(u_if.busy);
    while (n_edges < 60) begin
      @(posedge clk);
      n_edges++;
      #1;
      if (u_if.done) break;
      n_busy += 32'(u_if.busy);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_bcd,
                              input logic [7:0] exp_an, input logic exp_ovf);
    check({tag, "_done"},     32'(u_if.done),        32'd1);
    check({tag, "_bcd"},      u_if.bcd,              exp_bcd);
    check({tag, "_an_on"},    32'(u_if.an_on),       32'(exp_an));
    check({tag, "_ovf"},      32'(u_if.overflow),    32'(exp_ovf));
    check({tag, "_nb_bcd"},   u_if_nb.bcd,           exp_bcd);
    check({tag, "_nb_an_on"}, 32'(u_if_nb.an_on),    32'h0);
  endtask

  task automatic run_conv(input string tag, input logic [W-1:0] val, input logic [31:0] exp_bcd,
                          input logic [7:0] exp_an, input logic exp_ovf);
    int n_edges, n_busy;
    accept(val);
    wait_done(n_edges, n_busy);
    check({tag, "_latency"}, 32'(n_edges), 32'd27);
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'd27);
    check_result(tag, exp_bcd, exp_an, exp_ovf);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(u_if.done), 32'd0);
    check({tag, "_hold_bcd"},   u_if.bcd,       exp_bcd);
    check({tag, "_idle"},       32'(u_if.busy), 32'd0);
  endtask

  initial begin
    int n_edges, n_busy;
    int seen_done;

    u_if.in_valid = 1'b1;
    u_if.value    = 27'd12345;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     32'(u_if.busy),     32'd0);
    check("rst_done",     32'(u_if.done),     32'd0);
    check("rst_ovf",      32'(u_if.overflow), 32'd0);
    check("rst_bcd",      u_if.bcd,           32'h0000_0000);
    check("rst_an_on",    32'(u_if.an_on),    32'hFE);
    check("rst_nb_an_on", 32'(u_if_nb.an_on), 32'h00);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    reset         = 1'b1;

    run_conv("zero",  27'd0,           32'h0000_0000, 8'hFE, 1'b0);
    run_conv("mixed", 27'd12_345_678,  32'h1234_5678, 8'h00, 1'b0);
    run_conv("k1",    27'd1_000,       32'h0000_1000, 8'hF0, 1'b0);
    run_conv("max",   27'd99_999_999,  32'h9999_9999, 8'h00, 1'b0);
    run_conv("ovf",   27'd100_000_000, 32'hFFFF_FFFF, 8'h00, 1'b1);
    run_conv("after_ovf", 27'd7,       32'h0000_0007, 8'hFE, 1'b0);

    // A request at edge 10 of a running conversion must be ignored.
    accept(27'd42);
    repeat (9) @(posedge clk);
    #1;
    u_if.in_valid = 1'b1;
    u_if.value    = 27'd77;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    wait_done(n_edges, n_busy);
    check("ign_latency", 32'(n_edges), 32'd17);
    check_result("ign", 32'h0000_0042, 8'hFC, 1'b0);

    // A request held during the done cycle is accepted on the next edge.
    u_if.in_valid = 1'b1;
    u_if.value    = 27'd77;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    check("b2b_busy", 32'(u_if.busy), 32'd1);
    wait_done(n_edges, n_busy);
    check("b2b_interval", 32'(n_edges + 1), 32'd28);
    check_result("b2b", 32'h0000_0077, 8'hFC, 1'b0);

    // Reset at edge 13 aborts the conversion.
    accept(27'd5555);
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy",  32'(u_if.busy),  32'd0);
    check("abort_done",  32'(u_if.done),  32'd0);
    check("abort_bcd",   u_if.bcd,        32'h0000_0000);
    check("abort_an_on", 32'(u_if.an_on), 32'hFE);
    reset = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (u_if.done) seen_done = 1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_conv("post_abort", 27'd5555, 32'h0000_5555, 8'hF0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_digits.md
# bin_to_bcd_digits

Sequential binary-to-BCD converter that feeds the eight-digit seven-segment display driver. It accepts an unsigned binary value and converts it with one double-dabble iteration per clock. It presents the result as eight packed BCD nibbles on the driver's 32-bit number input, plus an 8-bit per-digit blanking mask on the driver's AN_ON input that suppresses leading zeros. It sits between the application datapath and the display driver, in the same clock domain.

## Interface
- W, 27: input value width. Fixed at 27, the minimum width holding 99_999_999; other values unsupported.
- BLANK_EN, 1: 1 = blank leading zero digits; 0 = an_on always 8'h00.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk.
- in_valid  in  1  request to convert value; honoured only when busy = 0.
- value  in  W  unsigned binary input, sampled on the accepting edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse; bcd/an_on/overflow updated in the same cycle.
- bcd  out  32  eight BCD digits; [3:0] = units (rightmost display digit), [31:28] = ten-millions.
- an_on  out  8  digit blanking mask; bit i = 1 forces digit i off (OR'd into anodes downstream).
- overflow  out  1  last accepted value exceeded 99_999_999; held until next done.

## Operation
- States: IDLE, SHIFT.
- IDLE: busy = 0. On an edge with in_valid = 1:
  - load a W-bit shift register with value;
  - clear the 32-bit BCD scratch register and iteration counter;
  - latch ovf_pend = (value > 99_999_999);
  - go to SHIFT.
- SHIFT: busy = 1. Each edge performs one iteration:
  - every scratch nibble >= 5 gets +3 (all eight in parallel, combinational);
  - shift {scratch, shift_reg} left by 1;
  - counter increments.
- The edge performing iteration W (counter == W-1) also commits:
  - bcd <= adjusted/shifted scratch, or 32'hFFFF_FFFF if ovf_pend;
  - overflow <= ovf_pend;
  - an_on <= mask (below);
  - done <= 1;
  - state <= IDLE.
- done is cleared on every other edge.
- Mask:
  - when BLANK_EN = 1 and not overflow, an_on[i] = 1 for i in 1..7 iff digits i..7 are all zero;
  - an_on[0] is always 0;
  - in every other case an_on = 8'h00.
- in_valid while busy = 1 is ignored: no queueing, no effect on the running conversion.
- bcd, an_on and overflow hold their values between done pulses; the display driver may sample them at any time.
- No internal nibble exceeds 9 for values <= 99_999_999. Overflowed values are not converted, but they take the same latency as any other value.

## Timing
- Reset (reset = 0 at an edge), output values:
  - state IDLE; busy 0; done 0; overflow 0; bcd 32'h0000_0000;
  - an_on 8'hFE if BLANK_EN else 8'h00.
  - Reset dominates in_valid.
- Reset mid-conversion aborts the conversion: no done, outputs take reset values.
- Latency:
  - accepting edge = edge 0;
  - busy = 1 from after edge 0 until after edge W;
  - done = 1 for exactly the cycle after edge W = 27.
- Throughput:
  - the state is IDLE in the done cycle, so in_valid asserted during the done cycle is accepted;
  - minimum issue interval is W+1 = 28 cycles.
- Outputs are fully registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then value 0 with in_valid -> done exactly 27 edges after acceptance; bcd 32'h0000_0000, an_on 8'hFE, overflow 0.
- Value 12_345_678 -> bcd 32'h1234_5678, an_on 8'h00; busy high for 27 cycles, done high for 1 cycle.
- Value 1_000 -> bcd 32'h0000_1000, an_on 8'hF0. Repeat with BLANK_EN = 0 -> an_on 8'h00.
- Value 99_999_999 -> bcd 32'h9999_9999, overflow 0. Then value 100_000_000 -> bcd 32'hFFFF_FFFF, overflow 1, an_on 8'h00.
- Accept 42 and pulse in_valid with 77 at edge 10 -> result 32'h0000_0042 only. Assert in_valid with 77 in the done cycle -> accepted; next done 28 cycles after the previous done, bcd 32'h0000_0077.
- Accept 5555, drive reset = 0 at edge 13 -> no done; bcd 0, an_on 8'hFE, busy 0. After reset release, a new conversion of 5555 completes normally.
